sys_ctrl: RTL and testbench
===========================

Name: sys_ctrl

Overview:
Command sequencer between the UART receive/transmit path and the ALU/register-file datapath. It parses byte frames from UART RX and generates register-file write and read strobes, ALU enable, function select and clock-gate enable. It returns read data or ALU results to UART TX one byte at a time. It is the only master of the register file and ALU ports.

Parameters:
WIDTH, 8, data/byte width
ADDR_W, 4, register-file address width
ALU_OUT_W, 16, ALU result width (2*WIDTH)
FUN_W, 4, ALU function-select width
ALU_TIMEOUT, 15, max cycles to wait for alu_valid before abort
CMD_WR, 8'hAA, register write: CMD, addr, data
CMD_RD, 8'hBB, register read: CMD, addr
CMD_ALU_OP, 8'hCC, ALU with operands: CMD, A, B, fun
CMD_ALU_NOP, 8'hDD, ALU on stored operands: CMD, fun

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  WIDTH  received byte
rx_valid  in  1  one-cycle pulse, rx_data valid
rf_rd_data  in  WIDTH  register-file read data
rf_rd_valid  in  1  register-file read data valid
alu_out  in  ALU_OUT_W  ALU result
alu_valid  in  1  ALU result valid
tx_busy  in  1  UART TX busy
rf_wr_en  out  1  register-file write strobe
rf_rd_en  out  1  register-file read strobe
rf_addr  out  ADDR_W  register-file address
rf_wr_data  out  WIDTH  register-file write data
alu_en  out  1  ALU operation strobe
alu_fun  out  FUN_W  ALU function select
clk_gate_en  out  1  ALU clock-gate enable
tx_data  out  WIDTH  byte to transmit
tx_valid  out  1  one-cycle transmit request
frame_drop  out  1  one-cycle pulse, rx byte discarded

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs registered and 0, result register 0, state IDLE. Reset at any point, including mid-frame or mid-TX, aborts the operation with no further strobes.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_SEND, TX_ACK.
- IDLE: on rx_valid, decode rx_data.
  - CMD_WR -> WR_ADDR; CMD_RD -> RD_ADDR; CMD_ALU_OP -> OP_A; CMD_ALU_NOP -> FUN.
  - Any other byte: stay in IDLE, no strobes, no frame_drop.
- WR_ADDR: on rx_valid, latch addr -> WR_DATA.
- WR_DATA: on rx_valid, the next cycle drives rf_wr_en=1 for exactly one cycle, with rf_addr=latched addr and rf_wr_data=rx_data -> IDLE.
- RD_ADDR: on rx_valid, the next cycle drives rf_rd_en=1 for one cycle with rf_addr=rx_data[ADDR_W-1:0] -> RD_WAIT.
- RD_WAIT: on rf_rd_valid, latch rf_rd_data as a 1-byte result -> TX_SEND.
- OP_A / OP_B: on rx_valid, a one-cycle write to address 0 (OP_A) or 1 (OP_B) -> next state.
- FUN: on rx_valid, the next cycle drives alu_fun=rx_data[FUN_W-1:0], alu_en=1 for one cycle and clk_gate_en=1 -> ALU_WAIT. alu_fun holds its value until the next FUN.
- ALU_WAIT: clk_gate_en stays 1.
  - On alu_valid: latch alu_out as a 2-byte result -> TX_SEND.
  - If alu_valid is not seen within ALU_TIMEOUT cycles after alu_en: -> IDLE, no TX.
  - clk_gate_en drops the cycle after leaving ALU_WAIT.
- TX_SEND: when tx_busy=0, drive tx_valid=1 for one cycle with tx_data=current byte (low byte first) -> TX_ACK.
- TX_ACK: wait for tx_busy=1, then tx_busy=0. If more bytes remain -> TX_SEND, else -> IDLE.
- A byte counter (1 bit) tracks bytes remaining.
- rx_valid while in RD_WAIT, ALU_WAIT, TX_SEND or TX_ACK: byte discarded, frame_drop pulses for one cycle, state unchanged.
- rf_wr_en and rf_rd_en are never high in the same cycle. Only one of rf_wr_en, rf_rd_en, alu_en is high per cycle.
- rx_valid arriving in the same cycle a strobe fires is processed normally, since strobes are registered.

Decomposition:
- Package sys_ctrl_pkg: state enum, command codes, default widths, byte-index constants.
- Optional sub-module sys_ctrl_tx_seq: the TX_SEND/TX_ACK byte serializer with result register and byte counter. The rest stays in sys_ctrl.

Test Plan:
- Write: rx 0xAA,0x05,0x3C → rf_wr_en high exactly 1 cycle with rf_addr=5, rf_wr_data=0x3C; no tx_valid.
- Read: rx 0xBB,0x05; model returns 0x3C with rf_rd_valid 1 cycle after rf_rd_en → rf_rd_en 1 cycle with addr 5; one tx_valid with tx_data=0x3C after tx_busy=0.
- ALU with operands: rx 0xCC,0x0A,0x03,0x00; ALU model returns 0x000D with alu_valid 1 cycle after alu_en →
  - writes reg0=0x0A, then reg1=0x03;
  - alu_fun=0, alu_en pulse, clk_gate_en high through ALU_WAIT;
  - tx 0x0D then 0x00, second byte only after a tx_busy high→low cycle.
- Timeout and drop: rx 0xDD,0x02 with alu_valid never asserted → return to IDLE after 15 cycles, no tx_valid, clk_gate_en low. A byte sent during the wait → frame_drop pulse.
- Unknown and reset: rx 0x55 → no strobes. rx 0xAA,0x07 then rst=1 for 1 cycle, then rx 0x99 → no rf_wr_en, state IDLE, 0x99 treated as an unknown command.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared constants, command codes and FSM state type for the command sequencer.
package sys_ctrl_pkg;

  localparam int WIDTH       = 8;
  localparam int ADDR_W      = 4;
  localparam int ALU_OUT_W   = 16;
  localparam int FUN_W       = 4;
  localparam int ALU_TIMEOUT = 15;

  // ALU wait timer: counts 0 .. ALU_TIMEOUT-1 while waiting for alu_valid
  localparam int TMR_W = $clog2(ALU_TIMEOUT + 1);

  localparam logic [WIDTH-1:0] CMD_WR      = 8'hAA;
  localparam logic [WIDTH-1:0] CMD_RD      = 8'hBB;
  localparam logic [WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots holding the ALU operands
  localparam logic [ADDR_W-1:0] OPA_ADDR = 4'd0;
  localparam logic [ADDR_W-1:0] OPB_ADDR = 4'd1;

  // Byte positions inside the result word; the low byte is sent first
  localparam int BYTE_LO = 0;
  localparam int BYTE_HI = 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_SEND  = 4'd9,
    TX_ACK   = 4'd10
  } state_t;

endpackage

// File: rtl/sys_ctrl_if.sv
// Bus bundle between the sequencer and UART / register file / ALU.
// master = the sequencer, slave = the surrounding datapath.
interface sys_ctrl_if;
  import sys_ctrl_pkg::*;

  logic [WIDTH-1:0]     rx_data;
  logic                 rx_valid;
  logic [WIDTH-1:0]     rf_rd_data;
  logic                 rf_rd_valid;
  logic [ALU_OUT_W-1:0] alu_out;
  logic                 alu_valid;
  logic                 tx_busy;
  logic                 rf_wr_en;
  logic                 rf_rd_en;
  logic [ADDR_W-1:0]    rf_addr;
  logic [WIDTH-1:0]     rf_wr_data;
  logic                 alu_en;
  logic [FUN_W-1:0]     alu_fun;
  logic                 clk_gate_en;
  logic [WIDTH-1:0]     tx_data;
  logic                 tx_valid;
  logic                 frame_drop;

  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_busy,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
           tx_data, tx_valid, frame_drop
  );

  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_busy,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
           tx_data, tx_valid, frame_drop
  );

endinterface

// File: rtl/sys_ctrl_tx_seq.sv
// Result serializer: holds a 1- or 2-byte result and hands it to UART TX
// low byte first, waiting for a full busy high->low handshake per byte.
module sys_ctrl_tx_seq
  import sys_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [ALU_OUT_W-1:0] word_i,
  input  logic                 two_i,
  input  logic                 tx_busy_i,
  output logic [WIDTH-1:0]     tx_data_o,
  output logic                 tx_valid_o,
  output logic                 done_o
);

  state_t               phase_q, phase_d;
  logic [ALU_OUT_W-1:0] res_q, res_d;
  logic                 cnt_q, cnt_d;     // bytes still to send after the current one
  logic                 seen_q, seen_d;   // tx_busy observed high for the current byte
  logic [WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 done_s;

  // Next-state logic for the send / acknowledge handshake
  always_comb begin
    phase_d    = phase_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    done_s     = 1'b0;
    case (phase_q)
      IDLE: begin
        if (load_i) begin
          phase_d = TX_SEND;
          res_d   = word_i;
          cnt_d   = two_i;
        end else begin
          phase_d = IDLE;
        end
      end
      TX_SEND: begin
        if (!tx_busy_i) begin
          tx_valid_d = 1'b1;
          tx_data_d  = res_q[BYTE_LO*WIDTH +: WIDTH];
          seen_d     = 1'b0;
          phase_d    = TX_ACK;
        end else begin
          phase_d = TX_SEND;
        end
      end
      TX_ACK: begin
        if (!seen_q) begin
          seen_d = tx_busy_i;
        end else if (!tx_busy_i) begin
          if (cnt_q) begin
            cnt_d   = 1'b0;
            res_d   = {{WIDTH{1'b0}}, res_q[BYTE_HI*WIDTH +: WIDTH]};
            phase_d = TX_SEND;
          end else begin
            phase_d = IDLE;
            done_s  = 1'b1;
          end
        end else begin
          seen_d = 1'b1;
        end
      end
      default: begin
        phase_d = IDLE;
      end
    endcase
  end

  // Serializer state and registered TX outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= IDLE;
      res_q      <= {ALU_OUT_W{1'b0}};
      cnt_q      <= 1'b0;
      seen_q     <= 1'b0;
      tx_data_q  <= {WIDTH{1'b0}};
      tx_valid_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign done_o     = done_s;

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: parses UART RX frames into register-file / ALU strobes
// and returns read data or ALU results through the TX serializer.
module sys_ctrl
  import sys_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  sys_ctrl_if.master bus
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ALU_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              rf_wr_en_q;
  logic              rf_rd_en_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [WIDTH-1:0]  rf_wr_data_q;
  logic              alu_en_q;
  logic [FUN_W-1:0]  alu_fun_q;
  logic              clk_gate_en_q;
  logic              frame_drop_q;

  logic                 tx_load_s;
  logic [ALU_OUT_W-1:0] tx_word_s;
  logic                 tx_two_s;
  logic                 tx_done_s;
  logic [WIDTH-1:0]     tx_data_s;
  logic                 tx_valid_s;

  // Hand a completed read (1 byte) or ALU result (2 bytes) to the serializer
  always_comb begin
    tx_load_s = 1'b0;
    tx_word_s = {ALU_OUT_W{1'b0}};
    tx_two_s  = 1'b0;
    case (state_q)
      RD_WAIT: begin
        if (bus.rf_rd_valid) begin
          tx_load_s = 1'b1;
          tx_word_s = {{(ALU_OUT_W-WIDTH){1'b0}}, bus.rf_rd_data};
        end else begin
          tx_load_s = 1'b0;
        end
      end
      ALU_WAIT: begin
        if (bus.alu_valid) begin
          tx_load_s = 1'b1;
          tx_word_s = bus.alu_out;
          tx_two_s  = 1'b1;
        end else begin
          tx_load_s = 1'b0;
        end
      end
      default: begin
        tx_load_s = 1'b0;
      end
    endcase
  end

  // Frame parser FSM with registered strobes; strobes default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      tmr_q         <= {TMR_W{1'b0}};
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= {ADDR_W{1'b0}};
      rf_wr_data_q  <= {WIDTH{1'b0}};
      alu_en_q      <= 1'b0;
      alu_fun_q     <= {FUN_W{1'b0}};
      clk_gate_en_q <= 1'b0;
      frame_drop_q  <= 1'b0;
    end else begin
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      frame_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_valid) begin
            case (bus.rx_data)
              CMD_WR:      state_q <= WR_ADDR;
              CMD_RD:      state_q <= RD_ADDR;
              CMD_ALU_OP:  state_q <= OP_A;
              CMD_ALU_NOP: state_q <= FUN;
              default:     state_q <= IDLE;   // unknown byte is silently ignored
            endcase
          end
        end
        WR_ADDR: begin
          if (bus.rx_valid) begin
            addr_q  <= bus.rx_data[ADDR_W-1:0];
            state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus.rx_valid) begin
            rf_wr_en_q   <= 1'b1;
            rf_addr_q    <= addr_q;
            rf_wr_data_q <= bus.rx_data;
            state_q      <= IDLE;
          end
        end
        RD_ADDR: begin
          if (bus.rx_valid) begin
            rf_rd_en_q <= 1'b1;
            rf_addr_q  <= bus.rx_data[ADDR_W-1:0];
            state_q    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          frame_drop_q <= bus.rx_valid;
          if (tx_load_s) begin
            state_q <= TX_SEND;
          end
        end
        OP_A: begin
          if (bus.rx_valid) begin
            rf_wr_en_q   <= 1'b1;
            rf_addr_q    <= OPA_ADDR;
            rf_wr_data_q <= bus.rx_data;
            state_q      <= OP_B;
          end
        end
        OP_B: begin
          if (bus.rx_valid) begin
            rf_wr_en_q   <= 1'b1;
            rf_addr_q    <= OPB_ADDR;
            rf_wr_data_q <= bus.rx_data;
            state_q      <= FUN;
          end
        end
        FUN: begin
          if (bus.rx_valid) begin
            alu_fun_q     <= bus.rx_data[FUN_W-1:0];
            alu_en_q      <= 1'b1;
            clk_gate_en_q <= 1'b1;
            tmr_q         <= {TMR_W{1'b0}};
            state_q       <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          // The alu_en cycle is the first of the ALU_TIMEOUT waiting cycles
          frame_drop_q <= bus.rx_valid;
          if (tx_load_s) begin
            clk_gate_en_q <= 1'b0;
            state_q       <= TX_SEND;
          end else if (tmr_q == TMO_LAST) begin
            clk_gate_en_q <= 1'b0;
            state_q       <= IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end
        TX_SEND, TX_ACK: begin
          // Byte-level handshaking lives in the serializer; wait for its done
          frame_drop_q <= bus.rx_valid;
          if (tx_done_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  sys_ctrl_tx_seq u_tx_seq (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load_s),
    .word_i     (tx_word_s),
    .two_i      (tx_two_s),
    .tx_busy_i  (bus.tx_busy),
    .tx_data_o  (tx_data_s),
    .tx_valid_o (tx_valid_s),
    .done_o     (tx_done_s)
  );

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.tx_data     = tx_data_s;
  assign bus.tx_valid    = tx_valid_s;
  assign bus.frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: frame tasks push expected strobes/bytes,
// a negedge monitor pops and compares; register file, ALU and UART TX are
// modelled behaviourally.
module tb_sys_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_ctrl_if bus_if ();
  sys_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct packed { logic [3:0] addr; logic [7:0] data; } wr_t;

  int checks = 0;
  int errors = 0;
  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  logic [3:0] fun_q[$];
  logic [7:0] tx_q[$];
  int         gate_q[$];
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic [7:0] rf_mem  [16] = '{default: 8'h00};
  int drops_exp = 0, drops_seen = 0, tx_seen = 0, gate_len = 0, tx_wait = 0;
  bit alu_silent = 1'b0;
  bit rd_pend = 1'b0, alu_pend = 1'b0;
  logic [3:0] rd_pend_addr = 4'h0, alu_pend_fun = 4'h0;
  int busy_cnt = 0;
  wr_t exp_wr;
  logic [7:0] exp_b;
  int exp_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      default: return {f, 4'h0, a ^ b};
    endcase
  endfunction

  // Monitor (compares against queues) followed by the environment models
  always @(negedge clk) begin
    if (bus_if.rf_wr_en | bus_if.rf_rd_en | bus_if.alu_en)
      check("single strobe", $countones({bus_if.rf_wr_en, bus_if.rf_rd_en, bus_if.alu_en}), 1);
    if (bus_if.rf_wr_en) begin
      if (wr_q.size() == 0) check("unexpected rf_wr_en", 1, 0);
      else begin
        exp_wr = wr_q.pop_front();
        check("wr addr", bus_if.rf_addr, exp_wr.addr);
        check("wr data", bus_if.rf_wr_data, exp_wr.data);
      end
    end
    if (bus_if.rf_rd_en) begin
      if (rd_q.size() == 0) check("unexpected rf_rd_en", 1, 0);
      else check("rd addr", bus_if.rf_addr, rd_q.pop_front());
    end
    if (bus_if.alu_en) begin
      check("gate at alu_en", bus_if.clk_gate_en, 1);
      if (fun_q.size() == 0) check("unexpected alu_en", 1, 0);
      else check("alu_fun", bus_if.alu_fun, fun_q.pop_front());
    end
    if (bus_if.clk_gate_en === 1'b1) gate_len++;
    else if (gate_len > 0) begin
      if (gate_q.size() == 0) check("unexpected clk_gate_en", gate_len, 0);
      else begin
        exp_g = gate_q.pop_front();
        check("clk_gate_en cycles", gate_len, exp_g);
      end
      gate_len = 0;
    end
    if (tx_wait == 1 && bus_if.tx_busy === 1'b1) tx_wait = 2;
    else if (tx_wait == 2 && bus_if.tx_busy === 1'b0) tx_wait = 0;
    if (bus_if.tx_valid) begin
      check("tx after busy cycle", tx_wait, 0);
      if (tx_q.size() == 0) check("unexpected tx_valid", 1, 0);
      else begin
        exp_b = tx_q.pop_front();
        check("tx_data", bus_if.tx_data, exp_b);
      end
      tx_seen++;
      tx_wait = 1;
    end
    if (bus_if.frame_drop) drops_seen++;

    // register file: read data one cycle after rf_rd_en
    if (bus_if.rf_wr_en) rf_mem[bus_if.rf_addr] = bus_if.rf_wr_data;
    bus_if.rf_rd_valid = rd_pend;
    bus_if.rf_rd_data  = rd_pend ? rf_mem[rd_pend_addr] : 8'($urandom);
    rd_pend      = bus_if.rf_rd_en;
    rd_pend_addr = bus_if.rf_addr;
    // ALU: result one cycle after alu_en unless silenced
    bus_if.alu_valid = alu_pend && !alu_silent;
    bus_if.alu_out   = alu_pend ? alu_ref(rf_mem[0], rf_mem[1], alu_pend_fun) : 16'($urandom);
    alu_pend     = bus_if.alu_en;
    alu_pend_fun = bus_if.alu_fun;
    // UART TX: busy for a random 1..4 cycles after each request
    if (bus_if.tx_valid) busy_cnt = $urandom_range(1, 4);
    bus_if.tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  // Caller is at a negedge; drives a one-cycle rx_valid pulse
  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size() + gate_q.size()) != 0
           || tx_wait != 0 || gate_len != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("idle wait budget", 1, 0);
        wr_q.delete(); rd_q.delete(); fun_q.delete(); tx_q.delete(); gate_q.delete();
        tx_wait = 0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back('{addr: a, data: d});
    ref_mem[a] = d;
    send_byte(8'hAA);
    send_byte({4'($urandom), a});
    send_byte(d);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic do_rd(input logic [3:0] a);
    rd_q.push_back(a);
    tx_q.push_back(ref_mem[a]);
    send_byte(8'hBB);
    send_byte({4'($urandom), a});
    wait_idle();
  endtask

  task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input bit drop);
    logic [15:0] r;
    int s, n;
    wr_q.push_back('{addr: 4'd0, data: a});
    wr_q.push_back('{addr: 4'd1, data: b});
    ref_mem[0] = a;
    ref_mem[1] = b;
    r = alu_ref(a, b, f[3:0]);
    fun_q.push_back(f[3:0]);
    gate_q.push_back(2);
    tx_q.push_back(r[7:0]);
    tx_q.push_back(r[15:8]);
    s = tx_seen;
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
    if (drop) begin
      n = 0;
      while (tx_seen == s && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (tx_seen == s) check("first tx byte budget", 1, 0);
      else begin
        drops_exp++;
        send_byte(8'($urandom));
      end
    end
    wait_idle();
  endtask

  task automatic do_alu_nop(input logic [7:0] f);
    logic [15:0] r;
    r = alu_ref(ref_mem[0], ref_mem[1], f[3:0]);
    fun_q.push_back(f[3:0]);
    gate_q.push_back(2);
    tx_q.push_back(r[7:0]);
    tx_q.push_back(r[15:8]);
    send_byte(8'hDD);
    send_byte(f);
    wait_idle();
  endtask

  function automatic logic [7:0] rand_unknown();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset outputs", {bus_if.rf_wr_en, bus_if.rf_rd_en, bus_if.rf_addr, bus_if.rf_wr_data,
                            bus_if.alu_en, bus_if.alu_fun, bus_if.clk_gate_en, bus_if.tx_data,
                            bus_if.tx_valid, bus_if.frame_drop}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed write, read and ALU-with-operands frames
    do_wr(4'd5, 8'h3C);
    wait_idle();
    do_rd(4'd5);
    do_alu_op(8'h0A, 8'h03, 8'h00, 1'b1);

    // ALU timeout with a byte dropped during the wait
    alu_silent = 1'b1;
    fun_q.push_back(4'h2);
    gate_q.push_back(15);
    send_byte(8'hDD);
    send_byte(8'h02);
    repeat (4) @(negedge clk);
    drops_exp++;
    send_byte(8'h77);
    repeat (30) @(negedge clk);
    check("gate low after timeout", bus_if.clk_gate_en, 0);
    alu_silent = 1'b0;
    wait_idle();

    // unknown command, then reset in the middle of a write frame
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    send_byte(8'hAA);
    send_byte(8'h07);
    rst = 1'b1;
    @(negedge clk);
    check("outputs after mid-frame reset", {bus_if.rf_wr_en, bus_if.rf_rd_en, bus_if.alu_en,
                                            bus_if.clk_gate_en, bus_if.tx_valid}, 32'h0);
    rst = 1'b0;
    send_byte(8'h99);
    repeat (3) @(negedge clk);
    do_wr(4'd7, 8'h5A);
    wait_idle();
    do_rd(4'd7);

    // randomized frame mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: do_wr(4'($urandom), 8'($urandom));
        1: do_rd(4'($urandom));
        2: do_alu_op(8'($urandom), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
        3: do_alu_nop(8'($urandom));
        default: begin
          send_byte(rand_unknown());
          repeat (2) @(negedge clk);
        end
      endcase
    end
    wait_idle();
    repeat (5) @(negedge clk);

    check("frame_drop count", drops_seen, drops_exp);
    check("queues drained", wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size() + gate_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
